ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
Parameters: name, default, meaning.
REQ-001 The block SHALL have parameter registerDataWidth, default 16, giving the ALU result and store data width.
REQ-002 The block SHALL have parameter regAddrWidth, default 4, giving the destination register address width.

Ports: name, direction, width, meaning.
REQ-003 The block SHALL have clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have reset, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have in_valid, input, 1: the execute stage presents an instruction.
REQ-006 The block SHALL have in_ready, output, 1: the block can accept an instruction this cycle.
REQ-007 The block SHALL have aluResult and storeData, input, registerDataWidth each: the ALU output and the rt operand.
REQ-008 The block SHALL have zeroFlag, input, 1: the ALU equality flag.
REQ-009 The block SHALL have rdAddr, input, regAddrWidth: the destination register.
REQ-010 The block SHALL have regWrite, memRead, memWrite and branch, input, 1 each: the control bits.
REQ-011 The block SHALL have flush, input, 1: discard all buffered and incoming instructions.
REQ-012 The block SHALL have out_valid, output, 1, and out_ready, input, 1: the memory-stage handshake.
REQ-013 The block SHALL have out_aluResult, out_storeData, out_rdAddr, out_regWrite, out_memRead and out_memWrite, outputs: the head-entry fields.
REQ-014 The block SHALL have branchTaken, output, 1: a one-cycle pulse for a resolved taken branch.
REQ-015 The block SHALL have ctrlError, output, 1: sticky flag for an illegal control combination.

Function
REQ-016 The block SHALL be a 2-entry in-order buffer with state machine EMPTY, ONE, FULL, held in registers.
REQ-017 A push SHALL occur when in_valid && in_ready && !flush && !branch.
REQ-018 A pop SHALL occur when out_valid && out_ready.
REQ-019 in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL; it SHALL be purely a function of state.
REQ-020 out_valid SHALL be 1 in ONE and FULL; the out_* fields SHALL show the oldest entry.
REQ-021 The latency from push to out_valid SHALL be 1 cycle.
REQ-022 State transitions SHALL be:
- EMPTY to ONE on push.
- ONE to FULL on push without pop.
- ONE to EMPTY on pop without push.
- ONE stays ONE on simultaneous push and pop.
- FULL to ONE on pop.
REQ-023 On simultaneous push and pop in ONE, the new entry SHALL become head on the next cycle.
REQ-024 While out_valid && !out_ready, the out_* fields SHALL remain stable.
REQ-025 An accepted instruction with branch=1 SHALL NOT be enqueued.
REQ-026 branchTaken SHALL be 1 in the cycle after acceptance iff zeroFlag=1, and 0 otherwise.
REQ-027 An accepted instruction with memRead=1 && memWrite=1 SHALL be enqueued with memWrite forced to 0.
REQ-028 The condition in REQ-027 SHALL set ctrlError, which stays 1 until reset.
REQ-029 flush=1 SHALL force the state to EMPTY on the next edge.
REQ-030 During a flush cycle, the input SHALL be discarded, no branchTaken pulse SHALL result, and any pop SHALL still be honoured upstream-visible, with contents discarded.
REQ-031 flush SHALL take priority over push, pop and branch resolution.
REQ-032 The data fields SHALL be copied unmodified: no width change, sign extension or arithmetic.

Reset
REQ-033 When reset=1 at a clock edge, the state SHALL become EMPTY.
REQ-034 After that edge, out_valid, branchTaken and ctrlError SHALL be 0 and in_ready SHALL be 1.
REQ-035 After that edge, all out_* data and control fields SHALL be 0.
REQ-036 Reset SHALL take priority over flush, push and pop, including mid-operation with FULL state.
REQ-037 Inputs SHALL be ignored during the reset cycle.

Verification
REQ-038 Push aluResult=0x0012, rdAddr=3, regWrite=1 with out_ready=1 -> next cycle out_valid=1, out_aluResult=0x0012, out_rdAddr=3; the following cycle out_valid=0.
REQ-039 Hold out_ready=0 and push 0x0001 then 0x0002 -> in_ready=0 with 0x0001 stable at the output; raise out_ready -> outputs 0x0001 then 0x0002 in order.
REQ-040 In ONE state, push 0x0005 while popping 0x0004 -> state remains ONE and the head becomes 0x0005.
REQ-041 Accept branch=1 with zeroFlag=1, then branch=1 with zeroFlag=0 -> branchTaken reads 1 then 0, and out_valid never rises.
REQ-042 In FULL, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the incoming entry is never output.
REQ-043 Push memRead=1 && memWrite=1 -> out_memWrite=0 and ctrlError=1 until reset; reset while FULL -> every output at its reset value on the next cycle.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: two-entry in-order EX/MEM pipeline buffer with branch resolution and control checking
//   clk, reset            : single rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   : execute-stage handshake (in_ready depends only on state)
//   aluResult, storeData, zeroFlag, rdAddr, regWrite, memRead, memWrite, branch : incoming instruction
//   flush                 : discard buffered and incoming instructions
//   out_valid / out_ready : memory-stage handshake; out_* show the oldest entry
//   branchTaken           : one-cycle pulse after accepting a taken branch
//   ctrlError             : sticky flag for memRead && memWrite on an enqueued instruction
module ex_mem_stage #(
    parameter int registerDataWidth = 16,
    parameter int regAddrWidth      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [registerDataWidth-1:0] aluResult,
    input  logic [registerDataWidth-1:0] storeData,
    input  logic                         zeroFlag,
    input  logic [regAddrWidth-1:0]      rdAddr,
    input  logic                         regWrite,
    input  logic                         memRead,
    input  logic                         memWrite,
    input  logic                         branch,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [registerDataWidth-1:0] out_aluResult,
    output logic [registerDataWidth-1:0] out_storeData,
    output logic [regAddrWidth-1:0]      out_rdAddr,
    output logic                         out_regWrite,
    output logic                         out_memRead,
    output logic                         out_memWrite,
    output logic                         branchTaken,
    output logic                         ctrlError
);
    localparam int EW = 2 * registerDataWidth + regAddrWidth + 3;
    localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [EW-1:0] head_q, head_d, tail_q, tail_d, in_entry;
    logic          bt_q, bt_d, err_q, err_d;
    logic          accept, push, pop;

    assign in_ready  = state_q != FULL;
    assign out_valid = state_q != EMPTY;
    assign {out_aluResult, out_storeData, out_rdAddr, out_regWrite, out_memRead, out_memWrite} = head_q;
    assign branchTaken = bt_q;
    assign ctrlError   = err_q;

    always_comb begin
        // accept covers branches too; only non-branch instructions are enqueued
        accept   = in_valid && in_ready && !flush;
        push     = accept && !branch;
        pop      = out_valid && out_ready;
        // a simultaneous read+write is demoted to a plain read
        in_entry = {aluResult, storeData, rdAddr, regWrite, memRead, memWrite && !memRead};
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (push) begin
                    state_d = ONE;
                    head_d  = in_entry;
                end
                ONE: if (push && pop) begin
                    head_d = in_entry;
                end else if (push) begin
                    state_d = FULL;
                    tail_d  = in_entry;
                end else if (pop) begin
                    state_d = EMPTY;
                end
                FULL: if (pop) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
                default: state_d = EMPTY;
            endcase
        end
        bt_d  = accept && branch && zeroFlag;
        err_d = err_q || (push && memRead && memWrite);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            bt_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            bt_q    <= bt_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed and random checks of ex_mem_stage against a queue-based reference model
module tb_ex_mem_stage;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, zeroFlag, regWrite, memRead, memWrite, branch, flush;
    logic        out_valid, out_ready, out_regWrite, out_memRead, out_memWrite, branchTaken, ctrlError;
    logic [15:0] aluResult, storeData, out_aluResult, out_storeData;
    logic [3:0]  rdAddr, out_rdAddr;

    typedef struct {
        logic [15:0] alu;
        logic [15:0] st;
        logic [3:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } ent_t;

    ent_t q[$];
    logic m_bt, m_err, m_zero;
    int   n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .aluResult(aluResult), .storeData(storeData), .zeroFlag(zeroFlag), .rdAddr(rdAddr),
        .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite), .branch(branch),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_aluResult(out_aluResult), .out_storeData(out_storeData), .out_rdAddr(out_rdAddr),
        .out_regWrite(out_regWrite), .out_memRead(out_memRead), .out_memWrite(out_memWrite),
        .branchTaken(branchTaken), .ctrlError(ctrlError)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: a FIFO of at most two entries; all decisions use its size before the edge.
    task automatic model_edge();
        int   sz;
        logic acc;
        ent_t e;
        sz = q.size();
        if (reset) begin
            q.delete();
            m_bt = 0; m_err = 0; m_zero = 1;
        end else if (flush) begin
            q.delete();
            m_bt = 0;
        end else begin
            acc = in_valid && sz < 2;
            if (sz > 0 && out_ready) void'(q.pop_front());
            if (acc && !branch) begin
                e.alu = aluResult; e.st = storeData; e.rd = rdAddr;
                e.rw = regWrite; e.mr = memRead; e.mw = memWrite && !memRead;
                q.push_back(e);
                if (memRead && memWrite) m_err = 1;
                m_zero = 0;
            end
            m_bt = acc && branch && zeroFlag;
        end
    endtask

    task automatic check_all();
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        chk("branchTaken", branchTaken, m_bt);
        chk("ctrlError", ctrlError, m_err);
        if (q.size() > 0) begin
            chk("head_alu", out_aluResult, q[0].alu);
            chk("head_st", out_storeData, q[0].st);
            chk("head_rd", out_rdAddr, q[0].rd);
            chk("head_ctl", {out_regWrite, out_memRead, out_memWrite}, {q[0].rw, q[0].mr, q[0].mw});
        end else if (m_zero) begin
            chk("reset_fields", {out_aluResult, out_storeData, out_rdAddr, out_regWrite, out_memRead, out_memWrite}, 0);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        in_valid = 0; aluResult = 0; storeData = 0; zeroFlag = 0; rdAddr = 0;
        regWrite = 0; memRead = 0; memWrite = 0; branch = 0; flush = 0; reset = 0; out_ready = 1;
    endtask

    task automatic push(input logic [15:0] a);
        in_valid = 1; aluResult = a; storeData = ~a; rdAddr = a[3:0]; regWrite = 1;
    endtask

    initial begin
        idle();
        reset = 1; in_valid = 1; aluResult = 16'hdead;
        tick();
        tick();
        idle();
        tick();
        // single push, one-cycle latency
        push(16'h0012); rdAddr = 3;
        tick();
        chk("r38_valid", out_valid, 1);
        chk("r38_alu", out_aluResult, 16'h0012);
        chk("r38_rd", out_rdAddr, 3);
        idle();
        tick();
        chk("r38_drain", out_valid, 0);
        // backpressure fills both entries
        out_ready = 0;
        push(16'h0001); tick();
        push(16'h0002); tick();
        chk("r39_full", in_ready, 0);
        chk("r39_head", out_aluResult, 16'h0001);
        in_valid = 0; tick();
        chk("r39_stable", out_aluResult, 16'h0001);
        out_ready = 1; tick();
        chk("r39_second", out_aluResult, 16'h0002);
        tick();
        chk("r39_empty", out_valid, 0);
        // simultaneous push and pop in ONE
        out_ready = 0; push(16'h0004); tick();
        out_ready = 1; push(16'h0005); tick();
        chk("r40_head", out_aluResult, 16'h0005);
        chk("r40_one", {out_valid, in_ready}, 2'b11);
        idle(); tick();
        // branches are resolved, not enqueued
        in_valid = 1; branch = 1; zeroFlag = 1; tick();
        chk("r41_taken", branchTaken, 1);
        chk("r41_noval", out_valid, 0);
        zeroFlag = 0; tick();
        chk("r41_nottaken", branchTaken, 0);
        chk("r41_noval2", out_valid, 0);
        idle(); tick();
        // flush from FULL
        out_ready = 0; push(16'h0007); tick(); push(16'h0008); tick();
        flush = 1; push(16'h0009); tick();
        chk("r42_valid", out_valid, 0);
        chk("r42_ready", in_ready, 1);
        idle(); tick();
        chk("r42_gone", out_valid, 0);
        // illegal control combination, then reset while FULL
        out_ready = 0; push(16'h000a); memRead = 1; memWrite = 1; tick();
        chk("r43_mw", out_memWrite, 0);
        chk("r43_err", ctrlError, 1);
        push(16'h000b); memRead = 0; memWrite = 0; tick();
        in_valid = 0; tick();
        chk("r43_sticky", ctrlError, 1);
        reset = 1; flush = 1; push(16'h000c); out_ready = 1; tick();
        chk("r43_rst", {out_valid, in_ready, branchTaken, ctrlError}, 4'b0100);
        chk("r43_fields", {out_aluResult, out_storeData, out_rdAddr, out_regWrite, out_memRead, out_memWrite}, 0);
        idle(); tick();
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            aluResult = 16'($urandom);
            storeData = 16'($urandom);
            rdAddr    = 4'($urandom);
            zeroFlag  = 1'($urandom);
            regWrite  = 1'($urandom);
            memRead   = 1'($urandom);
            memWrite  = $urandom_range(0, 3) == 0;
            branch    = $urandom_range(0, 5) == 0;
            flush     = $urandom_range(0, 19) == 0;
            reset     = $urandom_range(0, 59) == 0;
            out_ready = $urandom_range(0, 2) != 0;
            tick();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
